// File: rtl/pulpemu_rst_pkg.sv
// Shared types and constants for the FPGA-emulation reset generator.
package pulpemu_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } rst_state_e;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_STRETCH = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam int unsigned MIN_SYNC_STAGES     = 2;
  localparam int unsigned MIN_DEBOUNCE_CYCLES = 2;
  localparam int unsigned MIN_STRETCH_CYCLES  = 2;

endpackage

// File: rtl/pulpemu_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset level.
module pulpemu_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulpemu_rst_gen.sv
// Reset generator for the PULP emulation top: synchronizes and debounces the button,
// waits for clock lock and stretches the chip reset release; also re-times JTAG TRST.
module pulpemu_rst_gen
  import pulpemu_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned STRETCH_CYCLES  = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_reset_i,
  input  logic       jtag_trst_ni,
  input  logic       clk_locked_i,
  output logic       rst_no,
  output logic       jtag_trst_no,
  output logic [1:0] state_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned ST_W = $clog2(STRETCH_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH_CYCLES - 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("SYNC_STAGES below minimum");
  end
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_db
    $error("DEBOUNCE_CYCLES below minimum");
  end
  if (STRETCH_CYCLES < MIN_STRETCH_CYCLES) begin : g_bad_st
    $error("STRETCH_CYCLES below minimum");
  end

  logic btn_s, trst_s, locked_s;

  pulpemu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_btn (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(btn_reset_i), .q_o(btn_s)
  );
  pulpemu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_trst (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(jtag_trst_ni), .q_o(trst_s)
  );
  pulpemu_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_lock (
    .clk_i (clk_i), .rst_ni(rst_ni), .d_i(clk_locked_i), .q_o(locked_s)
  );

  logic            btn_db_q, btn_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      state_q, state_d;
  logic [ST_W-1:0] st_cnt_q, st_cnt_d;
  logic            rst_q, trst_q;
  logic            abort;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // A press aborts on the very edge it is accepted; a release is seen one edge later.
  assign abort = btn_db_d | ~locked_s;

  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (!abort && !btn_db_q) begin
          state_d  = ST_STRETCH;
          st_cnt_d = '0;
        end
      end
      ST_STRETCH: begin
        st_cnt_d = st_cnt_q + ST_W'(1);
        if (abort) begin
          state_d = ST_HOLD;
        end else if (st_cnt_q == ST_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
      state_q  <= ST_HOLD;
      st_cnt_q <= '0;
      rst_q    <= 1'b0;
      trst_q   <= 1'b0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      st_cnt_q <= st_cnt_d;
      rst_q    <= (state_d == ST_RUN);
      trst_q   <= trst_s & locked_s;
    end
  end

  assign rst_no       = rst_q;
  assign jtag_trst_no = trst_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pulpemu_rst_gen.sv
// Directed bench for pulpemu_rst_gen with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8.
module tb_pulpemu_rst_gen;

  logic       clk_i;
  logic       rst_ni;
  logic       btn_reset_i;
  logic       jtag_trst_ni;
  logic       clk_locked_i;
  logic       rst_no;
  logic       jtag_trst_no;
  logic [1:0] state_o;

  int n_checks;
  int n_errors;
  logic [0:0] exp_q[$];

  pulpemu_rst_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .STRETCH_CYCLES (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .btn_reset_i (btn_reset_i),
    .jtag_trst_ni(jtag_trst_ni),
    .clk_locked_i(clk_locked_i),
    .rst_no      (rst_no),
    .jtag_trst_no(jtag_trst_no),
    .state_o     (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_ni       = 1'b0;
    btn_reset_i  = 1'b0;
    jtag_trst_ni = 1'b1;
    clk_locked_i = 1'b1;

    // Clean power-up
    tick(3);
    check_eq("reset_rst_no", rst_no, 0);
    check_eq("reset_state", state_o, 0);
    check_eq("reset_jtag", jtag_trst_no, 0);
    rst_ni = 1'b1;
    for (int e = 1; e <= 16; e++) exp_q.push_back((e >= 15) ? 1'b1 : 1'b0);
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      check_eq("pwrup_rst_no", rst_no, exp_q.pop_front());
      if (e == 2) check_eq("pwrup_jtag_e2", jtag_trst_no, 0);
      if (e == 3) check_eq("pwrup_jtag_e3", jtag_trst_no, 1);
    end
    check_eq("pwrup_state_run", state_o, 2);

    // Bounce rejection: 3-cycle pulse
    btn_reset_i = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      tick(1);
      if (e == 3) btn_reset_i = 1'b0;
      check_eq("bounce_rst_no", rst_no, 1);
      check_eq("bounce_state", state_o, 2);
    end

    // Button press and release
    btn_reset_i = 1'b1;
    tick(5);
    check_eq("press_e5_rst_no", rst_no, 1);
    tick(1);
    check_eq("press_e6_rst_no", rst_no, 0);
    check_eq("press_e6_state", state_o, 0);
    check_eq("press_jtag", jtag_trst_no, 1);
    tick(4);
    btn_reset_i = 1'b0;
    tick(6);
    check_eq("release_e6_state", state_o, 0);
    tick(1);
    check_eq("release_e7_state", state_o, 1);
    tick(7);
    check_eq("release_e14_rst_no", rst_no, 0);
    tick(1);
    check_eq("release_e15_rst_no", rst_no, 1);
    check_eq("release_e15_state", state_o, 2);

    // Lock loss at stretch count 5, coinciding with the terminal count
    btn_reset_i = 1'b1;
    tick(10);
    check_eq("lock_pre_hold", state_o, 0);
    btn_reset_i = 1'b0;
    tick(12);
    check_eq("lock_in_stretch", state_o, 1);
    clk_locked_i = 1'b0;
    tick(2);
    check_eq("lock_e2_state", state_o, 1);
    tick(1);
    check_eq("lock_e3_state", state_o, 0);
    check_eq("lock_e3_jtag", jtag_trst_no, 0);
    check_eq("lock_e3_rst_no", rst_no, 0);
    tick(3);
    clk_locked_i = 1'b1;
    tick(2);
    check_eq("relock_e2_state", state_o, 0);
    tick(1);
    check_eq("relock_e3_state", state_o, 1);
    check_eq("relock_e3_jtag", jtag_trst_no, 1);
    tick(7);
    check_eq("relock_e10_state", state_o, 1);
    check_eq("relock_e10_rst_no", rst_no, 0);
    tick(1);
    check_eq("relock_e11_rst_no", rst_no, 1);
    check_eq("relock_e11_state", state_o, 2);

    // Late lock at power-up
    rst_ni       = 1'b0;
    clk_locked_i = 1'b0;
    tick(3);
    check_eq("late_reset_rst_no", rst_no, 0);
    check_eq("late_reset_state", state_o, 0);
    rst_ni = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      tick(1);
      check_eq("late_wait_rst_no", rst_no, 0);
      check_eq("late_wait_jtag", jtag_trst_no, 0);
    end
    clk_locked_i = 1'b1;
    tick(2);
    check_eq("late_e2_state", state_o, 0);
    check_eq("late_e2_jtag", jtag_trst_no, 0);
    tick(1);
    check_eq("late_e3_state", state_o, 1);
    check_eq("late_e3_jtag", jtag_trst_no, 1);
    tick(7);
    check_eq("late_e10_rst_no", rst_no, 0);
    tick(1);
    check_eq("late_e11_rst_no", rst_no, 1);
    check_eq("late_e11_state", state_o, 2);

    // Mid-sequence reset during STRETCH
    clk_locked_i = 1'b0;
    tick(4);
    check_eq("mid_hold_state", state_o, 0);
    clk_locked_i = 1'b1;
    tick(3);
    check_eq("mid_stretch_state", state_o, 1);
    tick(2);
    rst_ni = 1'b0;
    tick(1);
    check_eq("mid_reset_rst_no", rst_no, 0);
    check_eq("mid_reset_state", state_o, 0);
    check_eq("mid_reset_jtag", jtag_trst_no, 0);
    rst_ni = 1'b1;
    tick(2);
    check_eq("mid_e2_jtag", jtag_trst_no, 0);
    tick(1);
    check_eq("mid_e3_jtag", jtag_trst_no, 1);
    tick(11);
    check_eq("mid_e14_rst_no", rst_no, 0);
    check_eq("mid_e14_state", state_o, 1);
    tick(1);
    check_eq("mid_e15_rst_no", rst_no, 1);
    check_eq("mid_e15_state", state_o, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
